// File: rtl/cla_gp_8bit.sv
// Registered 8-bit two-level carry-lookahead adder leaf.
// Exposes the full carry vector and C0-independent group G/P.
module cla_gp_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       C0,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] S,
  output logic [7:0] C,
  output logic       G,
  output logic       P
);

  // Returns {Px, Gx, c3, c2, c1} with flattened lookahead terms.
  function automatic logic [4:0] cla4(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       cin
  );
    logic c1, c2, c3, gx, px;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0])
       | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1])
       | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & cin);
    gx = g[3] | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    px = &p;
    return {px, gx, c3, c2, c1};
  endfunction

  logic [7:0] g, p;
  logic [4:0] lo, hi;
  logic [7:0] s_d, s_q;
  logic [7:0] c_d, c_q;
  logic       g_d, g_q;
  logic       p_d, p_q;

  always_comb begin
    g        = A & B;
    p        = A ^ B;
    c_d      = '0;
    lo       = cla4(g[3:0], p[3:0], C0);
    c_d[2:0] = lo[2:0];
    // Carry into the hi block comes from level 2, not lo's ripple.
    c_d[3]   = lo[3] | (lo[4] & C0);
    hi       = cla4(g[7:4], p[7:4], c_d[3]);
    c_d[6:4] = hi[2:0];
    g_d      = hi[3] | (hi[4] & lo[3]);
    p_d      = hi[4] & lo[4];
    c_d[7]   = g_d | (p_d & C0);
    s_d      = p ^ {c_d[6:0], C0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= '0;
      g_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      g_q <= g_d;
      p_q <= p_d;
    end
  end

  assign S = s_q;
  assign C = c_q;
  assign G = g_q;
  assign P = p_q;

endmodule

// File: tb/tb_cla_gp_8bit.sv
// Directed and random checks for cla_gp_8bit.
// Inputs change 1ns after a rising edge; outputs sampled 1ns after the next.
module tb_cla_gp_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       C0;
  logic [7:0] A, B;
  logic [7:0] S, C;
  logic       G, P;

  int errors = 0;
  int checks = 0;

  cla_gp_8bit dut (
    .clk(clk), .rst(rst), .C0(C0),
    .A(A), .B(B),
    .S(S), .C(C), .G(G), .P(P)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    A = 8'hFF; B = 8'hFF; C0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({S, C, G, P} !== 18'h0)
      $display("FAIL reset got S=%h C=%h G=%b P=%b exp zeros",
               S, C, G, P);
    if ({S, C, G, P} !== 18'h0) errors++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (S !== 8'hFF || C !== 8'hFF || G !== 1'b1 || P !== 1'b0) begin
      errors++;
      $display("FAIL first_after_reset got S=%h C=%h G=%b P=%b exp ff ff 1 0",
               S, C, G, P);
    end
  endtask

  task automatic test_small_adds();
    logic [7:0] ta [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h10};
    logic [7:0] tb [5] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h00};
    logic [7:0] es [5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h10};
    logic [7:0] ec [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h00};
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; C0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (S !== es[i] || C !== ec[i] || G !== 1'b0 || P !== 1'b0) begin
        errors++;
        $display("FAIL small_add%0d got S=%h C=%h G=%b P=%b exp S=%h C=%h G=0 P=0",
                 i, S, C, G, P, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] ta [4] = '{8'h04, 8'hFF, 8'hFF, 8'h80};
    logic [7:0] tb [4] = '{8'h1F, 8'h00, 8'h00, 8'h80};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [4] = '{8'h23, 8'h00, 8'hFF, 8'h00};
    logic [7:0] ec [4] = '{8'h1C, 8'hFF, 8'h00, 8'h80};
    logic       eg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ep [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      A = ta[i]; B = tb[i]; C0 = tc[i];
      @(posedge clk); #1;
      checks++;
      if (S !== es[i] || C !== ec[i] || G !== eg[i] || P !== ep[i]) begin
        errors++;
        $display("FAIL boundary%0d got S=%h C=%h G=%b P=%b exp S=%h C=%h G=%b P=%b",
                 i, S, C, G, P, es[i], ec[i], eg[i], ep[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, es, ec;
    logic       c0, eg, ep, tog, pg, pp;
    int         rk, m, t;
    a = 8'h00; b = 8'h00; c0 = 1'b0;
    pg = 1'b0; pp = 1'b0;
    rk = int'($urandom_range(100, 9900));
    for (int k = 0; k < 10000; k++) begin
      if (k == rk) begin
        rst = 1'b1;
        A = 8'($urandom); B = 8'($urandom); C0 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({S, C, G, P} !== 18'h0) begin
          errors++;
          $display("FAIL mid_reset got S=%h C=%h G=%b P=%b exp zeros",
                   S, C, G, P);
        end
        rst = 1'b0;
      end else begin
        tog = (k % 2 == 1) && (k - 1 != rk);
        if (tog) begin
          c0 = ~c0;
        end else begin
          a = 8'($urandom); b = 8'($urandom); c0 = 1'($urandom);
        end
        A = a; B = b; C0 = c0;
        t  = int'(a) + int'(b) + int'(c0);
        es = t[7:0];
        for (int i = 0; i < 8; i++) begin
          m = (1 << (i + 1)) - 1;
          t = (int'(a) & m) + (int'(b) & m) + int'(c0);
          ec[i] = t[i+1];
        end
        t  = int'(a) + int'(b);
        eg = t[8];
        ep = &(a ^ b);
        @(posedge clk); #1;
        checks++;
        if (S !== es || C !== ec || G !== eg || P !== ep) begin
          errors++;
          $display("FAIL rand%0d %h+%h+%b got S=%h C=%h G=%b P=%b exp S=%h C=%h G=%b P=%b",
                   k, a, b, c0, S, C, G, P, es, ec, eg, ep);
        end
        checks++;
        if (C[7] !== (G | (P & c0))) begin
          errors++;
          $display("FAIL cout_identity%0d got C7=%b exp %b",
                   k, C[7], G | (P & c0));
        end
        if (tog) begin
          checks++;
          if (G !== pg || P !== pp) begin
            errors++;
            $display("FAIL gp_c0_indep%0d got G=%b P=%b exp G=%b P=%b",
                     k, G, P, pg, pp);
          end
        end
        pg = G; pp = P;
      end
    end
  endtask

  initial begin
    rst = 1'b1; A = 8'h00; B = 8'h00; C0 = 1'b0;
    test_reset();
    test_small_adds();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
